// File: rtl/mul_sched_pkg.sv
// mul_sched_pkg: shared state encoding and index-width helper for the multiplier scheduler.
package mul_sched_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  function automatic int clog2(input int n);
    int r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational rotating-priority pick, first set bit at or above ptr_i with wrap.
module rr_arbiter import mul_sched_pkg::*; #(
  parameter int N = 4,
  localparam int IW = clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o,
  output logic          any_o
);
  // Scanning from the farthest offset down lets the nearest requester win last.
  always_comb begin
    idx_o = '0;
    for (int i = N - 1; i >= 0; i--)
      idx_o = req_i[(int'(ptr_i) + i) % N] ? IW'((int'(ptr_i) + i) % N) : idx_o;
    any_o = |req_i;
    gnt_o = any_o ? N'(1) << idx_o : '0;
  end
endmodule

// File: rtl/mul_scheduler.sv
// mul_scheduler: round-robin sharing of one iterative multiplier between N_REQ requesters.
// Optional WAIT watchdog enabled by defining MUL_SCHED_TIMEOUT_EN.
module mul_scheduler import mul_sched_pkg::*; #(
  parameter int C_WIDTH        = 16,
  parameter int N_REQ          = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                       ctl_clk,
  input  logic                       reset,
  input  logic [N_REQ-1:0]           req,
  input  logic [N_REQ*C_WIDTH-1:0]   req_a,
  input  logic [N_REQ*C_WIDTH-1:0]   req_b,
  input  logic [N_REQ-1:0]           req_signed,
  output logic [N_REQ-1:0]           ack,
  output logic [N_REQ-1:0]           rsp_valid,
  output logic [C_WIDTH-1:0]         rsp_y,
  output logic                       rsp_err,
  output logic                       busy,
  output logic [C_WIDTH-1:0]         mul_a,
  output logic [C_WIDTH-1:0]         mul_b,
  output logic                       mul_signed,
  output logic                       mul_trigger,
  input  logic                       mul_ready,
  input  logic                       mul_done,
  input  logic [C_WIDTH-1:0]         mul_y
);
  localparam int IW = clog2(N_REQ);
  state_t state_q, state_d;
  logic [IW-1:0] ptr_q, ptr_d, idx_q, idx_d, gidx;
  logic [N_REQ-1:0] sel_q, sel_d, gnt;
  logic [C_WIDTH-1:0] a_q, a_d, b_q, b_d, y_q, y_d;
  logic s_q, s_d, any;
  rr_arbiter #(.N(N_REQ)) u_arb (
    .req_i(req), .ptr_i(ptr_q), .gnt_o(gnt), .idx_o(gidx), .any_o(any)
  );
`ifdef MUL_SCHED_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] cnt_q, cnt_d;
  logic err_q, err_d;
  assign rsp_err = err_q;
`else
  logic unused_to;
  assign unused_to = ^TIMEOUT_CYCLES;
  assign rsp_err = 1'b0;
`endif
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    idx_d   = idx_q;
    sel_d   = sel_q;
    a_d     = a_q;
    b_d     = b_q;
    s_d     = s_q;
    y_d     = y_q;
`ifdef MUL_SCHED_TIMEOUT_EN
    cnt_d   = cnt_q;
    err_d   = err_q;
`endif
    case (state_q)
      IDLE: if (mul_ready && any) begin
        idx_d   = gidx;
        sel_d   = gnt;
        a_d     = req_a[int'(gidx)*C_WIDTH +: C_WIDTH];
        b_d     = req_b[int'(gidx)*C_WIDTH +: C_WIDTH];
        s_d     = req_signed[gidx];
        state_d = ISSUE;
      end
      ISSUE: state_d = WAIT;
      WAIT: if (mul_done) begin
        y_d     = mul_y;
        state_d = RESP;
`ifdef MUL_SCHED_TIMEOUT_EN
        err_d   = 1'b0;
        cnt_d   = '0;
      end else if (cnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
        y_d     = '0;
        err_d   = 1'b1;
        cnt_d   = '0;
        state_d = RESP;
      end else begin
        cnt_d   = cnt_q + 1'b1;
`endif
      end
      RESP: begin
        ptr_d   = (idx_q == IW'(N_REQ - 1)) ? '0 : idx_q + 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge ctl_clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      idx_q   <= '0;
      sel_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      s_q     <= 1'b0;
      y_q     <= '0;
`ifdef MUL_SCHED_TIMEOUT_EN
      cnt_q   <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      idx_q   <= idx_d;
      sel_q   <= sel_d;
      a_q     <= a_d;
      b_q     <= b_d;
      s_q     <= s_d;
      y_q     <= y_d;
`ifdef MUL_SCHED_TIMEOUT_EN
      cnt_q   <= cnt_d;
      err_q   <= err_d;
`endif
    end
  end
  assign ack         = (state_q == ISSUE) ? sel_q : '0;
  assign rsp_valid   = (state_q == RESP) ? sel_q : '0;
  assign busy        = state_q != IDLE;
  assign mul_trigger = state_q == ISSUE;
  assign mul_a       = a_q;
  assign mul_b       = b_q;
  assign mul_signed  = s_q;
  assign rsp_y       = y_q;
endmodule

// File: tb/tb_mul_scheduler.sv
// tb_mul_scheduler: directed bench for mul_scheduler with a behavioural multiplier of variable latency.
module tb_mul_scheduler;
  localparam int W = 8;
  localparam int N = 4;
  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;
  logic [N-1:0] req = '0, req_signed = '0;
  logic [N*W-1:0] req_a = '0, req_b = '0;
  logic [N-1:0] ack, rsp_valid, g;
  logic [W-1:0] rsp_y, mul_a, mul_b, mul_y, prod;
  logic rsp_err, busy, mul_signed, mul_trigger, mul_ready, mul_done, mbusy;
  int lat = 1, mcnt, nvec = 0, nerr = 0, seen = 0;
  bit kill = 1'b0;
  mul_scheduler #(.C_WIDTH(W), .N_REQ(N), .TIMEOUT_CYCLES(16)) dut (
    .ctl_clk(clk), .reset(rst_n), .req(req), .req_a(req_a), .req_b(req_b),
    .req_signed(req_signed), .ack(ack), .rsp_valid(rsp_valid), .rsp_y(rsp_y),
    .rsp_err(rsp_err), .busy(busy), .mul_a(mul_a), .mul_b(mul_b),
    .mul_signed(mul_signed), .mul_trigger(mul_trigger), .mul_ready(mul_ready),
    .mul_done(mul_done), .mul_y(mul_y)
  );
  // Low W bits of the product are the same for signed and unsigned operands.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mbusy <= 1'b0; mul_ready <= 1'b1; mul_done <= 1'b0; mul_y <= '0; mcnt <= 0; prod <= '0;
    end else begin
      mul_done <= 1'b0;
      if (mul_trigger) begin
        mbusy <= 1'b1; mul_ready <= 1'b0; mcnt <= lat; prod <= mul_a * mul_b;
      end else if (mbusy) begin
        if (mcnt == 1) begin
          mbusy <= 1'b0; mul_ready <= 1'b1; mul_done <= !kill; mul_y <= prod;
        end else mcnt <= mcnt - 1;
      end
    end
  end
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic check_zero(input string tag);
    check({tag, "_ack"}, 32'(ack), 0);
    check({tag, "_rsp_valid"}, 32'(rsp_valid), 0);
    check({tag, "_rsp_y"}, 32'(rsp_y), 0);
    check({tag, "_rsp_err"}, 32'(rsp_err), 0);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_mul_ab"}, {16'h0, mul_a, mul_b}, 0);
    check({tag, "_mul_ctl"}, {30'h0, mul_signed, mul_trigger}, 0);
  endtask
  task automatic wait_ack(output logic [N-1:0] gr);
    for (int k = 0; k < 50 && ack == '0; k++) @(negedge clk);
    gr = ack;
    check("ack_seen", 32'(|ack), 1);
  endtask
  task automatic wait_rsp(input logic [N-1:0] v, input logic [W-1:0] y, input logic err);
    for (int k = 0; k < 200 && rsp_valid == '0; k++) @(negedge clk);
    check("rsp_valid", 32'(rsp_valid), 32'(v));
    check("rsp_y", 32'(rsp_y), 32'(y));
    check("rsp_err", 32'(rsp_err), 32'(err));
    @(negedge clk);
    check("idle_after_rsp", 32'(busy), 0);
  endtask
  task automatic op(input int i, input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                    input logic [W-1:0] y);
    req[i] = 1'b1; req_a[i*W +: W] = a; req_b[i*W +: W] = b; req_signed[i] = s;
    @(negedge clk);
    check("ack_latency", 32'(ack), 32'(1) << i);
    check("trigger", 32'(mul_trigger), 1);
    check("mul_ab", {16'h0, mul_a, mul_b}, {16'h0, a, b});
    check("mul_signed", 32'(mul_signed), 32'(s));
    req[i] = 1'b0;
    wait_rsp(N'(1) << i, y, 1'b0);
  endtask
  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
  initial begin
    repeat (2) @(negedge clk);
    check_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);
    for (int t = 0; t < 4; t++) begin
      lat = 1 + 3 * t;
      op(0, 8'h75, 8'h13, 1'b0, 8'hAF);
      op(3, 8'h05, 8'hFD, 1'b1, 8'hF1);
      op(1, 8'hFF, 8'hFF, 1'b1, 8'h01);
      op(2, 8'h80, 8'h02, 1'b0, 8'h00);
    end
    // All four requesting from reset: strict rotation 0,1,2,3,0,1.
    lat = 2;
    rst_n = 1'b0;
    req_signed = '0;
    for (int i = 0; i < N; i++) begin
      req_a[i*W +: W] = 8'(i + 1); req_b[i*W +: W] = 8'h03;
    end
    req = 4'hF;
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      wait_ack(g);
      check("rr_order", 32'(g), 32'(1) << (k % 4));
      wait_rsp(g, 8'(3 * ((k % 4) + 1)), 1'b0);
    end
    // req[2] held, req[1] joins after first grant: 2,1,2,1.
    rst_n = 1'b0;
    req = 4'b0100;
    req_a[2*W +: W] = 8'h07; req_b[2*W +: W] = 8'h09;
    req_a[1*W +: W] = 8'h06; req_b[1*W +: W] = 8'h07;
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      wait_ack(g);
      check("starve_order", 32'(g), (k % 2 == 0) ? 32'h4 : 32'h2);
      req[1] = 1'b1;
      wait_rsp(g, (k % 2 == 0) ? 8'h3F : 8'h2A, 1'b0);
    end
    req = '0;
    // Reset asserted while waiting on the multiplier.
    lat = 16;
    req_a[0 +: W] = 8'h0C; req_b[0 +: W] = 8'h0B;
    req = 4'b0001;
    wait_ack(g);
    check("mid_ack", 32'(g), 1);
    repeat (4) @(negedge clk);
    check("mid_busy", 32'(busy), 1);
    #2 rst_n = 1'b0;
    #1 check_zero("mid_reset");
    @(negedge clk);
    check("reset_held_no_rsp", 32'(rsp_valid), 0);
    rst_n = 1'b1;
    wait_ack(g);
    check("reack", 32'(g), 1);
    req = '0;
    wait_rsp(4'b0001, 8'h84, 1'b0);
    // Multiplier never signals done.
    lat = 4;
    kill = 1'b1;
    req_a[0 +: W] = 8'h03; req_b[0 +: W] = 8'h03;
    req = 4'b0001;
    wait_ack(g);
    req = '0;
`ifdef MUL_SCHED_TIMEOUT_EN
    wait_rsp(4'b0001, 8'h00, 1'b1);
`else
    repeat (40) begin
      @(negedge clk);
      if (rsp_valid != '0) seen++;
    end
    check("no_rsp_without_done", 32'(seen), 0);
    check("busy_stuck", 32'(busy), 1);
`endif
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
